// File: rtl/aes_reg_master_if.sv
// REG_BUS initiator/target signal bundle: one transfer per valid&ready edge,
// with read data and error returned on that same edge.
interface aes_reg_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  error;

  modport master (output addr, write, wdata, wstrb, valid,
                  input  rdata, ready, error);
  modport slave  (input  addr, write, wdata, wstrb, valid,
                  output rdata, ready, error);
endinterface

// File: rtl/aes_reg_master.sv
// Runs one AES-192 job (plaintext, optional key slot load, select, start, poll, readback)
// on the peripheral register map per core request; one idle bus cycle after every completion.
module aes_reg_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned POLL_MAX   = 256,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [127:0]  pt_i,
  input  logic [191:0]  key_i,
  input  logic [1:0]    key_slot_i,
  input  logic          key_load_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [127:0]  ct_o,
  output logic [1:0]    resp_err_o,
  output logic          busy_o,
  aes_reg_master_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PT, S_WR_KEY, S_WR_SEL, S_START_HI,
    S_START_LO, S_POLL, S_RD_CT, S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_idx, w_idx_nxt;
  logic                  r_vld, w_vld_nxt;
  logic [15:0]           r_poll_cnt, w_poll_nxt, w_poll_inc;
  logic [1:0]            r_err, w_err_nxt;
  logic [127:0]          r_pt, r_ct;
  logic [191:0]          r_key;
  logic [1:0]            r_slot;
  logic                  r_kload;
  logic                  w_cpl, w_accept, w_ct_clr, w_ct_cap;
  logic [5:0]            w_off, w_key_base;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign req_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign resp_err_o   = r_err;
  assign ct_o         = r_ct;

  assign w_accept   = req_valid_i & req_ready_o;
  assign w_cpl      = r_vld & bus.ready;
  assign w_poll_inc = r_poll_cnt + 16'd1;

  // Address and data are decoded from the registered state, so they cannot move while valid is up.
  assign bus.valid = r_vld;
  assign bus.addr  = r_vld ? (ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(w_off) << 2)) : '0;
  assign bus.write = r_vld & w_write;
  assign bus.wdata = r_vld ? w_wdata : '0;
  assign bus.wstrb = 4'hF;

  always_comb begin
    case (r_slot)
      2'd0:    w_key_base = 6'd5;
      2'd1:    w_key_base = 6'd20;
      default: w_key_base = 6'd26;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_vld      <= 1'b0;
      r_poll_cnt <= 16'd0;
      r_err      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_vld      <= w_vld_nxt;
      r_poll_cnt <= w_poll_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_poll_nxt  = r_poll_cnt;
    w_err_nxt   = r_err;
    w_ct_clr    = 1'b0;
    w_ct_cap    = 1'b0;
    w_off       = 6'd0;
    w_write     = 1'b0;
    w_wdata     = '0;
    w_vld_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = S_WR_PT;
          w_idx_nxt   = 3'd0;
          w_err_nxt   = 2'd0;
        end
      end
      S_WR_PT: begin
        w_off   = 6'd1 + {3'b0, r_idx};
        w_write = 1'b1;
        w_wdata = r_pt[{r_idx[1:0], 5'b0} +: 32];
        if (w_cpl) begin
          if (r_idx == 3'd3) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = r_kload ? S_WR_KEY : S_WR_SEL;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      S_WR_KEY: begin
        w_off   = w_key_base + {3'b0, r_idx};
        w_write = 1'b1;
        w_wdata = r_key[{r_idx, 5'b0} +: 32];
        if (w_cpl) begin
          if (r_idx == 3'd5) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = S_WR_SEL;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      S_WR_SEL: begin
        w_off   = 6'd32;
        w_write = 1'b1;
        w_wdata = {30'b0, r_slot};
        if (w_cpl) w_state_nxt = S_START_HI;
      end
      S_START_HI: begin
        w_off   = 6'd0;
        w_write = 1'b1;
        w_wdata = 32'd1;
        if (w_cpl) w_state_nxt = S_START_LO;
      end
      S_START_LO: begin
        w_off   = 6'd0;
        w_write = 1'b1;
        w_wdata = 32'd0;
        if (w_cpl) begin
          w_state_nxt = S_POLL;
          w_poll_nxt  = 16'd0;
        end
      end
      S_POLL: begin
        w_off = 6'd11;
        if (w_cpl) begin
          if (bus.rdata[0]) begin
            w_state_nxt = S_RD_CT;
            w_idx_nxt   = 3'd0;
          end else begin
            w_poll_nxt = w_poll_inc;
            if (32'(w_poll_inc) >= POLL_MAX) begin
              w_state_nxt = S_RESP;
              w_err_nxt   = 2'd2;
              w_ct_clr    = 1'b1;
            end
          end
        end
      end
      S_RD_CT: begin
        w_off = 6'd12 + {3'b0, r_idx};
        if (w_cpl) begin
          w_ct_cap  = 1'b1;
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd3) w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A bus error on any completion overrides whatever the state decided.
    if (w_cpl && bus.error) begin
      w_state_nxt = S_RESP;
      w_err_nxt   = 2'd1;
      w_ct_clr    = 1'b1;
      w_ct_cap    = 1'b0;
    end
    w_vld_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_RESP) && !w_cpl;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pt    <= '0;
      r_key   <= '0;
      r_slot  <= 2'd0;
      r_kload <= 1'b0;
      r_ct    <= '0;
    end else begin
      if (w_accept) begin
        r_pt    <= pt_i;
        r_key   <= key_i;
        r_slot  <= (key_slot_i == 2'd3) ? 2'd2 : key_slot_i;
        r_kload <= key_load_i;
        r_ct    <= '0;
      end else if (w_ct_clr) begin
        r_ct <= '0;
      end else if (w_ct_cap) begin
        r_ct[{r_idx[1:0], 5'b0} +: 32] <= bus.rdata;
      end
    end
  end

endmodule
